uart_rx_cfg: RTL
================

// Module: uart_rx_cfg
// PURPOSE
//  Second-generation UART receiver: oversampled serial input, run-time frame format
//  (5..DATA_WIDTH data bits, optional even/odd parity, 1 or 2 stop bits), 3-sample
//  majority voting, break detection, and a valid/ready output with overrun reporting.
//  Sits between the RX pad synchroniser domain and the system-side RX FIFO/regfile.
// PARAMETERS
//  DATA_WIDTH   9   max data bits per frame; P_DATA width
//  PRESC_W      6   width of Prescale (oversampling ratio, clocks per bit)
//  LEN_W        4   width of data_len
// PORTS
//  CLK           in   1           receiver clock (Prescale x baud)
//  RST           in   1           synchronous, active-high reset
//  RX_IN         in   1           serial line, idle high, async (2-flop synced inside)
//  PAR_EN        in   1           1 = parity bit present
//  PAR_TYP       in   1           0 = even (bit = ^data), 1 = odd (bit = ~^data)
//  STOP2         in   1           1 = two stop bits checked
//  data_len      in   LEN_W       data bits per frame; <5 -> 5, >DATA_WIDTH -> DATA_WIDTH
//  Prescale      in   PRESC_W     clocks per bit; legal 6..2^PRESC_W-1, <6 treated as 6
//  P_DATA        out  DATA_WIDTH  received word, LSB = first bit, unused MSBs = 0
//  data_valid    out  1           P_DATA/flags valid; held until data_ready
//  data_ready    in   1           consumer accepts word when data_valid & data_ready
//  Parity_Error  out  1           qualified by data_valid
//  Stop_Error    out  1           framing error, qualified by data_valid
//  Break_Det     out  1           break frame, qualified by data_valid
//  Overrun       out  1           1-cycle pulse: completed frame dropped
// BEHAVIOUR
//  - Reset (RST=1 at posedge CLK): FSM=IDLE, counters 0, sync flops 1, all outputs 0.
//    RST mid-frame aborts the frame; no data_valid for it.
//  - RX_IN passes a 2-flop synchroniser (2-cycle latency); all sampling on synced value.
//  - States: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
//  - IDLE: synced 1->0 transition -> START; edge_cnt=0; PAR_EN, PAR_TYP, STOP2,
//    data_len, Prescale latched here; later changes ignored until next IDLE.
//  - edge_cnt counts 0..P-1 per bit (P = latched Prescale), wraps to 0 at bit end.
//    Samples taken at edge_cnt = P/2-1, P/2, P/2+1; bit value = majority of 3,
//    resolved at edge_cnt = P/2+1 (integer divide; odd P allowed).
//  - START: voted 1 -> false start, return to IDLE at the resolve point.
//    Voted 0 -> DATA at bit end, bit_cnt=0.
//  - DATA: shift LSB first; after bit data_len-1 -> PARITY if PAR_EN else STOP1.
//  - PARITY: mismatch with computed parity sets par_err.
//  - STOP1/STOP2: voted 0 sets frm_err. The final stop bit completes the frame at its
//    resolve point (mid-bit): no wait for the bit end. FSM goes to IDLE the next
//    cycle, so a start edge in the second half of the stop bit is still caught.
//  - Break: all data bits, the parity slot (if any) and the first stop bit vote 0 ->
//    Break_Det=1, Stop_Error=1, P_DATA=0. The FSM goes to BRK_WAIT until synced
//    RX_IN=1, then to IDLE.
//  - Delivery: on frame completion with data_valid=0, next cycle data_valid=1 with
//    P_DATA and the flags. data_valid stays high, outputs stable, until the cycle
//    after data_valid & data_ready.
//  - Completion while data_valid=1 and data_ready=0: the new frame is dropped and
//    Overrun pulses 1 cycle. The old word is kept.
//  - Completion in the same cycle as a handshake: the new word is loaded next cycle.
//    data_valid stays 1 and there is no overrun.
//  - Latency: data_valid rises 1 clk after the last stop-bit resolve point
//    (2 clk synchroniser delay excluded).
// STRUCTURE
//  - Shared package uart_pkg: rx state enum/localparams, MIN_PRESCALE=6,
//    MIN_DATA_LEN=5, parity function (even/odd).
//  - Sub-module uart_rx_sampler: synchroniser, edge_cnt, 3-sample majority,
//    start-edge detect. Outputs bit_val, bit_strobe (resolve point), bit_end.
//  - Top level: FSM, bit_cnt, shift register, error/break logic, output holding
//    register with handshake.
// TESTING
//  1 8N1, P=32, PAR_EN=0: send 0xBB -> P_DATA=0x0BB, data_valid, no flags.
//  2 8E1 P=16 and 8O1 P=8: send 0xBB with correct parity -> 0xBB, Parity_Error=0.
//    Flip the parity bit -> Parity_Error=1, data still 0xBB.
//  3 7-bit, STOP2=1, P=16: send 0x5A with second stop=0 -> P_DATA=0x05A,
//    Stop_Error=1. Inject 1-clk glitch at mid-bit on each data bit -> majority
//    vote gives 0x5A.
//  4 False start: 3-clk low pulse, P=16 -> no data_valid, FSM back in IDLE.
//    Line low 12 bit-times (8E1) -> Break_Det=1, Stop_Error=1, P_DATA=0, no new
//    frame until line is high.
//  5 data_ready=0: send 0x11 then 0x22 back-to-back -> 0x11 held, Overrun pulse 1 clk.
//    Raise data_ready -> 0x11 consumed, data_valid=0.
//  6 RST mid-frame (after bit 3) -> outputs 0, no data_valid.
//    Next frame 0xA5 8N1 P=8 -> 0xA5, clean.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM encoding,
// frame-format limits and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BRK_WAIT
    } rx_state_e;

    localparam int MIN_PRESCALE = 6;
    localparam int MIN_DATA_LEN = 5;

    // Expected parity bit; unused data MSBs must be zero.
    function automatic logic parity_bit(input logic [31:0] data, input logic odd);
        return odd ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// System-side word interface of the receiver.
// valid/ready: the receiver raises data_valid with P_DATA and the flags and holds
// them stable until the cycle after data_valid & data_ready are both high at posedge.
interface uart_rx_cfg_if #(
    parameter int DATA_WIDTH = 9
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  data_ready;
    logic                  Parity_Error;
    logic                  Stop_Error;
    logic                  Break_Det;
    logic                  Overrun;

    modport master (
        output P_DATA, data_valid, Parity_Error, Stop_Error, Break_Det, Overrun,
        input  data_ready
    );

    modport slave (
        input  P_DATA, data_valid, Parity_Error, Stop_Error, Break_Det, Overrun,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser, per-bit edge counter, 3-sample
// majority vote and start-edge detection.
module uart_rx_sampler #(
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               i_rx,
    input  logic               i_run,
    input  logic [PRESC_W-1:0] i_presc,
    output logic               o_rx_sync,
    output logic               o_start_edge,
    output logic               o_bit_val,
    output logic               o_bit_strobe,
    output logic               o_bit_end
);
    logic               r_sync1, r_sync2, r_sync3;
    logic               r_s0, r_s1;
    logic [PRESC_W-1:0] r_edge_cnt;
    logic [PRESC_W-1:0] w_half, w_pt0, w_pt2, w_last;

    assign w_half = i_presc >> 1;
    assign w_pt0  = w_half - PRESC_W'(1);
    assign w_pt2  = w_half + PRESC_W'(1);
    assign w_last = i_presc - PRESC_W'(1);

    assign o_rx_sync    = r_sync2;
    assign o_start_edge = r_sync3 & ~r_sync2;
    // Third sample is the live synced value, so the vote resolves in the P/2+1 cycle.
    assign o_bit_val    = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
    assign o_bit_strobe = i_run && (r_edge_cnt == w_pt2);
    assign o_bit_end    = i_run && (r_edge_cnt == w_last);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_sync3    <= 1'b1;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_edge_cnt <= '0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (!i_run || o_bit_end) begin
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
            end
            if (i_run && r_edge_cnt == w_pt0) r_s0 <= r_sync2;
            if (i_run && r_edge_cnt == w_half) r_s1 <= r_sync2;
        end
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM, data assembly, parity/framing/break
// detection and a single-word holding register with overrun reporting.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 9,
    parameter int PRESC_W    = 6,
    parameter int LEN_W      = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic               STOP2,
    input  logic [LEN_W-1:0]   data_len,
    input  logic [PRESC_W-1:0] Prescale,
    uart_rx_cfg_if.master      rx_if,
    output rx_state_e          o_dbg_state
);
    rx_state_e             r_state, w_state_nxt;
    logic                  r_par_en, r_par_typ, r_stop2;
    logic [LEN_W-1:0]      r_len, r_bit_cnt, w_len_cl;
    logic [PRESC_W-1:0]    r_presc, w_presc_cl;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_err, r_frm_err, r_all_zero;

    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_valid, r_perr_o, r_serr_o, r_brk_o, r_overrun;

    logic w_rx_sync, w_start_edge, w_bit_val, w_bit_strobe, w_bit_end, w_run;
    logic w_last_bit, w_brk, w_done, w_done_ferr;

    always_comb begin
        w_len_cl = data_len;
        if (data_len < LEN_W'(MIN_DATA_LEN)) begin
            w_len_cl = LEN_W'(MIN_DATA_LEN);
        end else if (data_len > LEN_W'(DATA_WIDTH)) begin
            w_len_cl = LEN_W'(DATA_WIDTH);
        end
        w_presc_cl = (Prescale < PRESC_W'(MIN_PRESCALE)) ? PRESC_W'(MIN_PRESCALE) : Prescale;
    end

    assign w_run = (r_state != ST_IDLE) && (r_state != ST_BRK_WAIT);

    uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
        .CLK          (CLK),
        .RST          (RST),
        .i_rx         (RX_IN),
        .i_run        (w_run),
        .i_presc      (r_presc),
        .o_rx_sync    (w_rx_sync),
        .o_start_edge (w_start_edge),
        .o_bit_val    (w_bit_val),
        .o_bit_strobe (w_bit_strobe),
        .o_bit_end    (w_bit_end)
    );

    assign w_last_bit  = (r_bit_cnt == r_len - LEN_W'(1));
    // Break: every slot up to and including the first stop bit voted low.
    assign w_brk       = (r_state == ST_STOP1) && w_bit_strobe && r_all_zero && !w_bit_val;
    assign w_done      = w_bit_strobe &&
                         (((r_state == ST_STOP1) && (w_brk || !r_stop2)) || (r_state == ST_STOP2));
    assign w_done_ferr = r_frm_err | ~w_bit_val;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:     if (w_start_edge) w_state_nxt = ST_START;
            ST_START: begin
                if (w_bit_strobe && w_bit_val) w_state_nxt = ST_IDLE;
                else if (w_bit_end)            w_state_nxt = ST_DATA;
            end
            ST_DATA:     if (w_bit_end && w_last_bit) w_state_nxt = r_par_en ? ST_PARITY : ST_STOP1;
            ST_PARITY:   if (w_bit_end) w_state_nxt = ST_STOP1;
            ST_STOP1: begin
                if (w_brk)                      w_state_nxt = ST_BRK_WAIT;
                else if (w_done)                w_state_nxt = ST_IDLE;
                else if (r_stop2 && w_bit_end)  w_state_nxt = ST_STOP2;
            end
            ST_STOP2:    if (w_bit_strobe) w_state_nxt = ST_IDLE;
            ST_BRK_WAIT: if (w_rx_sync) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_stop2    <= 1'b0;
            r_len      <= LEN_W'(MIN_DATA_LEN);
            r_presc    <= PRESC_W'(MIN_PRESCALE);
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_all_zero <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                        r_stop2    <= STOP2;
                        r_len      <= w_len_cl;
                        r_presc    <= w_presc_cl;
                        r_bit_cnt  <= '0;
                        r_shift    <= '0;
                        r_par_err  <= 1'b0;
                        r_frm_err  <= 1'b0;
                        r_all_zero <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_strobe) begin
                        r_shift[r_bit_cnt] <= w_bit_val;
                        r_all_zero         <= r_all_zero & ~w_bit_val;
                    end
                    if (w_bit_end && !w_last_bit) r_bit_cnt <= r_bit_cnt + LEN_W'(1);
                end
                ST_PARITY: begin
                    if (w_bit_strobe) begin
                        r_par_err  <= w_bit_val != parity_bit(32'(r_shift), r_par_typ);
                        r_all_zero <= r_all_zero & ~w_bit_val;
                    end
                end
                ST_STOP1: if (w_bit_strobe) r_frm_err <= ~w_bit_val;
                default: ;
            endcase
        end
    end

    // Holding register: a completion coinciding with a handshake reloads in place.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_p_data  <= '0;
            r_valid   <= 1'b0;
            r_perr_o  <= 1'b0;
            r_serr_o  <= 1'b0;
            r_brk_o   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_done) begin
                if (!r_valid || rx_if.data_ready) begin
                    r_p_data <= w_brk ? '0 : r_shift;
                    r_perr_o <= r_par_err;
                    r_serr_o <= w_done_ferr;
                    r_brk_o  <= w_brk;
                    r_valid  <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_if.data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_if.P_DATA       = r_p_data;
    assign rx_if.data_valid   = r_valid;
    assign rx_if.Parity_Error = r_perr_o;
    assign rx_if.Stop_Error   = r_serr_o;
    assign rx_if.Break_Det    = r_brk_o;
    assign rx_if.Overrun      = r_overrun;
    assign o_dbg_state        = r_state;
endmodule
